// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: widths, opcodes, station tags, empty-slot
// sentinels, reservation-station state encoding and the ADD/SUB ALU helper.
package tomasulo_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned TAG_W  = 3;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned CNT_W  = 4;

  // Opcodes
  localparam logic [OP_W-1:0] OP_LD  = 3'd0;
  localparam logic [OP_W-1:0] OP_ST  = 3'd1;
  localparam logic [OP_W-1:0] OP_ADD = 3'd2;
  localparam logic [OP_W-1:0] OP_SUB = 3'd3;

  // Station tags; FREE means "value already present"
  localparam logic [TAG_W-1:0] TAG_FREE  = 3'd0;
  localparam logic [TAG_W-1:0] TAG_ADD1  = 3'd1;
  localparam logic [TAG_W-1:0] TAG_ADD2  = 3'd2;
  localparam logic [TAG_W-1:0] TAG_LOAD1 = 3'd3;
  localparam logic [TAG_W-1:0] TAG_LOAD2 = 3'd4;

  // Empty-slot sentinels
  localparam logic [DATA_W-1:0] V_SEM_VALOR = 16'hFFF0;
  localparam logic [TAG_W-1:0]  Q_SEM_VALOR = 3'd0;

  typedef enum logic [1:0] {
    RS_IDLE     = 2'd0,
    RS_WAIT_OPS = 2'd1,
    RS_EXEC     = 2'd2,
    RS_WB       = 2'd3
  } rs_state_t;

  // 16-bit modulo ADD/SUB; unknown opcodes behave as ADD
  function automatic logic [DATA_W-1:0] alu_addsub(input logic [OP_W-1:0]   op,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
    if (op == OP_SUB) return DATA_W'(a - b);
    return DATA_W'(a + b);
  endfunction

endpackage

// File: rtl/estacao_reserva_add_operand_snoop.sv
// operand_snoop: one V/Q operand slot. Captures the dispatched value/tag,
// snoops the CDB for its pending tag and reports whether Q is 0 after the
// current edge.
// Macro RS_ISSUE_BYPASS_EN: a CDB broadcast matching the incoming tag on the
// capture edge is taken directly instead of latching the tag.
// Ports: Clock, Reset (async, active-high), load (capture), snoop_en,
//   v_in/q_in (dispatch), cdb_valid/cdb_tag/cdb_data, v/q (held operand),
//   ready_nxt_c (Q will be 0 after this edge).
module operand_snoop
  import tomasulo_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              load,
  input  logic              snoop_en,
  input  logic [DATA_W-1:0] v_in,
  input  logic [TAG_W-1:0]  q_in,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic [DATA_W-1:0] v,
  output logic [TAG_W-1:0]  q,
  output logic              ready_nxt_c
);

  logic              hit_in;
  logic              hit_held;
  logic [DATA_W-1:0] v_nxt;
  logic [TAG_W-1:0]  q_nxt;

  assign hit_held = cdb_valid && (cdb_tag != Q_SEM_VALOR) && (cdb_tag == q);

`ifdef RS_ISSUE_BYPASS_EN
  assign hit_in = cdb_valid && (cdb_tag != Q_SEM_VALOR) && (cdb_tag == q_in);
`else
  assign hit_in = 1'b0;
`endif

  // Next operand contents: capture (with optional bypass) or snoop
  always_comb begin
    v_nxt = v;
    q_nxt = q;
    if (load) begin
      if (hit_in) begin
        v_nxt = cdb_data;
        q_nxt = Q_SEM_VALOR;
      end else begin
        v_nxt = v_in;
        q_nxt = q_in;
      end
    end else if (snoop_en && hit_held) begin
      v_nxt = cdb_data;
      q_nxt = Q_SEM_VALOR;
    end
  end

  assign ready_nxt_c = (q_nxt == Q_SEM_VALOR);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      v <= V_SEM_VALOR;
      q <= Q_SEM_VALOR;
    end else begin
      v <= v_nxt;
      q <= q_nxt;
    end
  end

endmodule

// File: rtl/estacao_reserva_add.sv
// estacao_reserva_add: single-entry ADD/SUB reservation station. Accepts one
// op from dispatch, waits for operand tags on the CDB, runs a fixed-latency
// ALU and broadcasts the result tagged RS_TAG once granted.
// Macro RS_ISSUE_BYPASS_EN (in operand_snoop): same-edge CDB capture at issue.
// Ports: Clock, Reset (async, active-high); dispatch Enable_VQ, Ufop, Vj, Vk,
//   Qj, Qk, R_target; CDB snoop CDB_Valid, CDB_Tag, CDB_Data; CDB_Grant;
//   outputs Busy, CDB_Req, CDB_Out_Valid, CDB_Out_Tag, CDB_Out_Data,
//   CDB_R_target.
module estacao_reserva_add
  import tomasulo_pkg::*;
#(
  parameter logic [TAG_W-1:0] RS_TAG  = 3'd1,
  parameter int unsigned      LATENCY = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Enable_VQ,
  input  logic [OP_W-1:0]   Ufop,
  input  logic [DATA_W-1:0] Vj,
  input  logic [DATA_W-1:0] Vk,
  input  logic [TAG_W-1:0]  Qj,
  input  logic [TAG_W-1:0]  Qk,
  input  logic [REG_W-1:0]  R_target,
  input  logic              CDB_Valid,
  input  logic [TAG_W-1:0]  CDB_Tag,
  input  logic [DATA_W-1:0] CDB_Data,
  input  logic              CDB_Grant,
  output logic              Busy,
  output logic              CDB_Req,
  output logic              CDB_Out_Valid,
  output logic [TAG_W-1:0]  CDB_Out_Tag,
  output logic [DATA_W-1:0] CDB_Out_Data,
  output logic [REG_W-1:0]  CDB_R_target
);

  rs_state_t         state, state_n;
  logic              load, snoop_en;
  logic              rdy_j, rdy_k;
  logic [DATA_W-1:0] vj_q, vk_q;
  logic [TAG_W-1:0]  qj_q, qk_q;
  logic [OP_W-1:0]   op_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              cnt_arm_q;
  logic [DATA_W-1:0] result_q;
  logic [REG_W-1:0]  rtgt_q;
  logic              busy_q, req_q;

  operand_snoop u_snoop_j (
    .Clock(Clock), .Reset(Reset), .load(load), .snoop_en(snoop_en),
    .v_in(Vj), .q_in(Qj), .cdb_valid(CDB_Valid), .cdb_tag(CDB_Tag),
    .cdb_data(CDB_Data), .v(vj_q), .q(qj_q), .ready_nxt_c(rdy_j)
  );

  operand_snoop u_snoop_k (
    .Clock(Clock), .Reset(Reset), .load(load), .snoop_en(snoop_en),
    .v_in(Vk), .q_in(Qk), .cdb_valid(CDB_Valid), .cdb_tag(CDB_Tag),
    .cdb_data(CDB_Data), .v(vk_q), .q(qk_q), .ready_nxt_c(rdy_k)
  );

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= RS_IDLE;
    else       state <= state_n;
  end

  // Next state and operand-slot control
  always_comb begin
    state_n  = state;
    load     = 1'b0;
    snoop_en = 1'b0;
    case (state)
      RS_IDLE: begin
        if (Enable_VQ) begin
          load    = 1'b1;
          state_n = (rdy_j && rdy_k) ? RS_EXEC : RS_WAIT_OPS;
        end
      end
      RS_WAIT_OPS: begin
        snoop_en = 1'b1;
        if (rdy_j && rdy_k) state_n = RS_EXEC;
      end
      RS_EXEC: begin
        if (!cnt_arm_q && (cnt_q == '0)) state_n = RS_WB;
      end
      RS_WB: begin
        if (CDB_Grant) state_n = RS_IDLE;
      end
      default: state_n = RS_IDLE;
    endcase
  end

  // First EXEC cycle arms the counter; result latched when it reaches zero
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      op_q      <= OP_ADD;
      rtgt_q    <= '0;
      cnt_q     <= '0;
      cnt_arm_q <= 1'b0;
      result_q  <= V_SEM_VALOR;
      busy_q    <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      busy_q <= (state_n != RS_IDLE);
      req_q  <= (state_n == RS_WB);
      if (load) begin
        op_q   <= Ufop;
        rtgt_q <= R_target;
      end
      if ((state != RS_EXEC) && (state_n == RS_EXEC)) cnt_arm_q <= 1'b1;
      if (state == RS_EXEC) begin
        if (cnt_arm_q) begin
          cnt_q     <= CNT_W'(LATENCY - 1);
          cnt_arm_q <= 1'b0;
        end else if (cnt_q != '0) begin
          cnt_q <= CNT_W'(cnt_q - 1'b1);
        end else begin
          result_q <= alu_addsub(op_q, vj_q, vk_q);
        end
      end
    end
  end

  assign Busy          = busy_q;
  assign CDB_Req       = req_q;
  assign CDB_Out_Valid = (state == RS_WB) && CDB_Grant;
  assign CDB_Out_Tag   = CDB_Out_Valid ? RS_TAG : TAG_FREE;
  assign CDB_Out_Data  = result_q;
  assign CDB_R_target  = rtgt_q;

endmodule

// File: tb/tb_estacao_reserva_add.sv
// Directed self-checking bench for estacao_reserva_add (RS_TAG=1, LATENCY=2).
module tb_estacao_reserva_add;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Enable_VQ;
  logic [2:0]  Ufop;
  logic [15:0] Vj, Vk;
  logic [2:0]  Qj, Qk;
  logic [3:0]  R_target;
  logic        CDB_Valid;
  logic [2:0]  CDB_Tag;
  logic [15:0] CDB_Data;
  logic        CDB_Grant;
  logic        Busy, CDB_Req, CDB_Out_Valid;
  logic [2:0]  CDB_Out_Tag;
  logic [15:0] CDB_Out_Data;
  logic [3:0]  CDB_R_target;

  int checks = 0;
  int errors = 0;

  estacao_reserva_add #(.RS_TAG(3'd1), .LATENCY(2)) dut (
    .Clock(Clock), .Reset(Reset), .Enable_VQ(Enable_VQ), .Ufop(Ufop),
    .Vj(Vj), .Vk(Vk), .Qj(Qj), .Qk(Qk), .R_target(R_target),
    .CDB_Valid(CDB_Valid), .CDB_Tag(CDB_Tag), .CDB_Data(CDB_Data),
    .CDB_Grant(CDB_Grant), .Busy(Busy), .CDB_Req(CDB_Req),
    .CDB_Out_Valid(CDB_Out_Valid), .CDB_Out_Tag(CDB_Out_Tag),
    .CDB_Out_Data(CDB_Out_Data), .CDB_R_target(CDB_R_target)
  );

  always #5 Clock = ~Clock;

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] qa, input logic [2:0] qb, input logic [3:0] rt);
    Enable_VQ = 1'b1; Ufop = op; Vj = a; Vk = b; Qj = qa; Qk = qb; R_target = rt;
    tick();
    Enable_VQ = 1'b0; Vj = 16'h0; Vk = 16'h0; Qj = 3'd0; Qk = 3'd0; R_target = 4'd0;
  endtask

  task automatic test_reset;
    Reset = 1'b1; Enable_VQ = 1'b0; Ufop = 3'd0; Vj = '0; Vk = '0; Qj = '0; Qk = '0;
    R_target = '0; CDB_Valid = 1'b0; CDB_Tag = '0; CDB_Data = '0; CDB_Grant = 1'b0;
    tick(); tick();
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0h expected 0", Busy); end
    checks++; if (CDB_Req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0h expected 0", CDB_Req); end
    checks++; if (CDB_Out_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0h expected 0", CDB_Out_Valid); end
    checks++; if (CDB_Out_Tag !== 3'd0) begin errors++; $display("FAIL reset_tag: got %0h expected 0", CDB_Out_Tag); end
    checks++; if (CDB_Out_Data !== 16'hFFF0) begin errors++; $display("FAIL reset_data: got %0h expected fff0", CDB_Out_Data); end
    checks++; if (CDB_R_target !== 4'd0) begin errors++; $display("FAIL reset_rtgt: got %0h expected 0", CDB_R_target); end
    Reset = 1'b0;
    tick();
  endtask

  // ADD 5+7, operands ready: Req appears 3 edges after issue edge
  task automatic test_add_ready;
    issue(3'd2, 16'd5, 16'd7, 3'd0, 3'd0, 4'd6);
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL add_busy: got %0h expected 1", Busy); end
    checks++; if (CDB_Req !== 1'b0) begin errors++; $display("FAIL add_req_e0: got %0h expected 0", CDB_Req); end
    tick();
    checks++; if (CDB_Req !== 1'b0) begin errors++; $display("FAIL add_req_e1: got %0h expected 0", CDB_Req); end
    tick();
    checks++; if (CDB_Req !== 1'b0) begin errors++; $display("FAIL add_req_e2: got %0h expected 0", CDB_Req); end
    tick();
    checks++; if (CDB_Req !== 1'b1) begin errors++; $display("FAIL add_req_e3: got %0h expected 1", CDB_Req); end
    checks++; if (CDB_Out_Data !== 16'd12) begin errors++; $display("FAIL add_data: got %0h expected c", CDB_Out_Data); end
    checks++; if (CDB_R_target !== 4'd6) begin errors++; $display("FAIL add_rtgt: got %0h expected 6", CDB_R_target); end
    checks++; if (CDB_Out_Valid !== 1'b0) begin errors++; $display("FAIL add_valid_nogrant: got %0h expected 0", CDB_Out_Valid); end
    CDB_Grant = 1'b1; #1;
    checks++; if (CDB_Out_Valid !== 1'b1) begin errors++; $display("FAIL add_valid_grant: got %0h expected 1", CDB_Out_Valid); end
    checks++; if (CDB_Out_Tag !== 3'd1) begin errors++; $display("FAIL add_tag: got %0h expected 1", CDB_Out_Tag); end
    tick();
    CDB_Grant = 1'b0; #1;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL add_busy_done: got %0h expected 0", Busy); end
    checks++; if (CDB_Req !== 1'b0) begin errors++; $display("FAIL add_req_done: got %0h expected 0", CDB_Req); end
    checks++; if (CDB_Out_Valid !== 1'b0) begin errors++; $display("FAIL add_valid_done: got %0h expected 0", CDB_Out_Valid); end
  endtask

  // SUB 0-1 with Qj pending: wraps to FFFF, no Req before operands resolve
  task automatic test_sub_wait;
    issue(3'd3, 16'h1234, 16'd1, 3'd3, 3'd0, 4'd2);
    for (int i = 0; i < 4; i++) begin
      checks++; if (CDB_Req !== 1'b0) begin errors++; $display("FAIL sub_early_req: got %0h expected 0", CDB_Req); end
      tick();
    end
    CDB_Valid = 1'b1; CDB_Tag = 3'd3; CDB_Data = 16'h0000;
    tick();
    CDB_Valid = 1'b0; CDB_Tag = 3'd0; CDB_Data = 16'h0;
    tick();
    checks++; if (CDB_Req !== 1'b0) begin errors++; $display("FAIL sub_req_x1: got %0h expected 0", CDB_Req); end
    tick();
    checks++; if (CDB_Req !== 1'b0) begin errors++; $display("FAIL sub_req_x2: got %0h expected 0", CDB_Req); end
    tick();
    checks++; if (CDB_Req !== 1'b1) begin errors++; $display("FAIL sub_req_x3: got %0h expected 1", CDB_Req); end
    checks++; if (CDB_Out_Data !== 16'hFFFF) begin errors++; $display("FAIL sub_data: got %0h expected ffff", CDB_Out_Data); end
    CDB_Grant = 1'b1; tick(); CDB_Grant = 1'b0;
    tick();
  endtask

  // Both operands wait for tag 4; a broadcast from tag 2 must not match
  task automatic test_both_tags;
    issue(3'd2, 16'hAAAA, 16'h5555, 3'd4, 3'd4, 4'd3);
    CDB_Valid = 1'b1; CDB_Tag = 3'd2; CDB_Data = 16'd100;
    tick();
    CDB_Valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (CDB_Req !== 1'b0) begin errors++; $display("FAIL both_wrong_tag_req: got %0h expected 0", CDB_Req); end
    CDB_Valid = 1'b1; CDB_Tag = 3'd4; CDB_Data = 16'd9;
    tick();
    CDB_Valid = 1'b0; CDB_Tag = 3'd0; CDB_Data = 16'h0;
    tick(); tick(); tick();
    checks++; if (CDB_Req !== 1'b1) begin errors++; $display("FAIL both_req: got %0h expected 1", CDB_Req); end
    checks++; if (CDB_Out_Data !== 16'd18) begin errors++; $display("FAIL both_data: got %0h expected 12", CDB_Out_Data); end
    CDB_Grant = 1'b1; tick(); CDB_Grant = 1'b0;
    tick();
  endtask

  // Grant withheld 10 cycles: request held, no broadcast, data stable
  task automatic test_grant_hold;
    issue(3'd2, 16'd100, 16'd200, 3'd0, 3'd0, 4'd9);
    tick(); tick(); tick();
    for (int i = 0; i < 10; i++) begin
      checks++; if (CDB_Req !== 1'b1) begin errors++; $display("FAIL hold_req: got %0h expected 1", CDB_Req); end
      checks++; if (CDB_Out_Valid !== 1'b0) begin errors++; $display("FAIL hold_valid: got %0h expected 0", CDB_Out_Valid); end
      checks++; if (CDB_Out_Data !== 16'd300) begin errors++; $display("FAIL hold_data: got %0h expected 12c", CDB_Out_Data); end
      tick();
    end
    CDB_Grant = 1'b1; #1;
    checks++; if (CDB_Out_Valid !== 1'b1) begin errors++; $display("FAIL hold_valid_grant: got %0h expected 1", CDB_Out_Valid); end
    checks++; if (CDB_Out_Tag !== 3'd1) begin errors++; $display("FAIL hold_tag: got %0h expected 1", CDB_Out_Tag); end
    checks++; if (CDB_R_target !== 4'd9) begin errors++; $display("FAIL hold_rtgt: got %0h expected 9", CDB_R_target); end
    tick();
    CDB_Grant = 1'b1; #1;
    checks++; if (CDB_Out_Valid !== 1'b0) begin errors++; $display("FAIL hold_one_shot: got %0h expected 0", CDB_Out_Valid); end
    CDB_Grant = 1'b0;
    tick();
  endtask

  // Enable while Busy ignored; Reset during EXEC aborts without broadcast
  task automatic test_busy_and_reset;
    issue(3'd2, 16'd1, 16'd2, 3'd0, 3'd0, 4'd3);
    issue(3'd3, 16'd50, 16'd50, 3'd0, 3'd0, 4'd7);
    tick(); tick();
    checks++; if (CDB_Req !== 1'b1) begin errors++; $display("FAIL busy_req: got %0h expected 1", CDB_Req); end
    checks++; if (CDB_Out_Data !== 16'd3) begin errors++; $display("FAIL busy_data: got %0h expected 3", CDB_Out_Data); end
    checks++; if (CDB_R_target !== 4'd3) begin errors++; $display("FAIL busy_rtgt: got %0h expected 3", CDB_R_target); end
    CDB_Grant = 1'b1; tick(); CDB_Grant = 1'b0;
    tick();
    issue(3'd2, 16'd10, 16'd20, 3'd0, 3'd0, 4'd5);
    tick();
    #2 Reset = 1'b1; #1;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0h expected 0", Busy); end
    checks++; if (CDB_Out_Data !== 16'hFFF0) begin errors++; $display("FAIL rst_data: got %0h expected fff0", CDB_Out_Data); end
    checks++; if (CDB_R_target !== 4'd0) begin errors++; $display("FAIL rst_rtgt: got %0h expected 0", CDB_R_target); end
    tick();
    Reset = 1'b0;
    CDB_Grant = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (CDB_Req !== 1'b0 || CDB_Out_Valid !== 1'b0) begin errors++; $display("FAIL rst_no_bcast: got req=%0h valid=%0h expected 0/0", CDB_Req, CDB_Out_Valid); end
    end
    CDB_Grant = 1'b0;
  endtask

  // Broadcast coinciding with issue
  task automatic test_issue_bypass;
    CDB_Valid = 1'b1; CDB_Tag = 3'd1; CDB_Data = 16'd6;
    issue(3'd2, 16'h0, 16'd4, 3'd1, 3'd0, 4'd1);
    CDB_Valid = 1'b0; CDB_Tag = 3'd0; CDB_Data = 16'h0;
`ifdef RS_ISSUE_BYPASS_EN
    tick(); tick(); tick();
    checks++; if (CDB_Req !== 1'b1) begin errors++; $display("FAIL bypass_req: got %0h expected 1", CDB_Req); end
    checks++; if (CDB_Out_Data !== 16'd10) begin errors++; $display("FAIL bypass_data: got %0h expected a", CDB_Out_Data); end
    CDB_Grant = 1'b1; tick(); CDB_Grant = 1'b0;
`else
    for (int i = 0; i < 8; i++) begin
      checks++; if (CDB_Req !== 1'b0 || Busy !== 1'b1) begin errors++; $display("FAIL nobypass_wait: got req=%0h busy=%0h expected 0/1", CDB_Req, Busy); end
      tick();
    end
    Reset = 1'b1; tick(); Reset = 1'b0;
`endif
    tick();
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL bypass_end_busy: got %0h expected 0", Busy); end
  endtask

  initial begin
    test_reset();
    test_add_ready();
    test_sub_wait();
    test_both_tags();
    test_grant_hold();
    test_busy_and_reset();
    test_issue_bypass();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
